// File: rtl/shared_adder_arbiter_if.sv
// Bundle of the two requester handshakes and the result channel of shared_adder_arbiter.
// The slave modport is the adder side; the master modport is the requesters and the consumer.
interface shared_adder_arbiter_if #(
    parameter int A_W   = 4,
    parameter int B_W   = 3,
    parameter int RES_W = 4,
    parameter int CNT_W = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [A_W-1:0]   req0_a;
    logic [B_W-1:0]   req0_b;
    logic             req0_mode;
    logic             req1_valid;
    logic             req1_ready;
    logic [A_W-1:0]   req1_a;
    logic [B_W-1:0]   req1_b;
    logic             req1_mode;
    logic             res_valid;
    logic             res_ready;
    logic [RES_W-1:0] res_data;
    logic             res_ovf;
    logic             res_id;
    logic [CNT_W-1:0] ovf_count;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_mode,
        input  req1_valid, req1_a, req1_b, req1_mode,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_data, res_ovf, res_id, ovf_count
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_mode,
        output req1_valid, req1_a, req1_b, req1_mode,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_data, res_ovf, res_id, ovf_count
    );
endinterface

// File: rtl/shared_adder_arbiter.sv
// One mixed-signedness adder shared by two requesters under round-robin arbitration,
// with a single-entry result register and a saturating overflow counter.
module shared_adder_arbiter #(
    parameter int A_W   = 4,
    parameter int B_W   = 3,
    parameter int RES_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    shared_adder_arbiter_if.slave  bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Extends a per its mode and b as signed, then adds at RES_W+1 bits.
    function automatic logic [RES_W:0] ext_sum(input logic [A_W-1:0] a,
                                               input logic [B_W-1:0] b,
                                               input logic           mode);
        logic [RES_W:0] a_ext;
        logic [RES_W:0] b_ext;
        if (mode) begin
            a_ext = {{(RES_W+1-A_W){a[A_W-1]}}, a};
        end else begin
            a_ext = {{(RES_W+1-A_W){1'b0}}, a};
        end
        b_ext = {{(RES_W+1-B_W){b[B_W-1]}}, b};
        return a_ext + b_ext;
    endfunction

    // The two top bits disagree exactly when the true sum leaves the signed RES_W range.
    function automatic logic sum_ovf(input logic [RES_W:0] sum);
        return sum[RES_W] ^ sum[RES_W-1];
    endfunction

    state_t           state_q, state_d;
    logic [RES_W-1:0] res_data_q, res_data_d;
    logic             res_ovf_q, res_ovf_d;
    logic             res_id_q, res_id_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

    logic             slot_free_s;
    logic             win1_s;
    logic             any_valid_s;
    logic             accept_s;
    logic [RES_W:0]   sum_s;
    logic             ovf_s;

    // Round-robin grant and operand selection for the current winner.
    always_comb begin
        win1_s      = 1'b0;
        slot_free_s = (state_q == EMPTY) || bus.res_ready;
        any_valid_s = bus.req0_valid || bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            win1_s = (last_q == 1'b0);
        end else if (bus.req1_valid) begin
            win1_s = 1'b1;
        end else begin
            win1_s = 1'b0;
        end
        if (win1_s) begin
            sum_s = ext_sum(bus.req1_a, bus.req1_b, bus.req1_mode);
        end else begin
            sum_s = ext_sum(bus.req0_a, bus.req0_b, bus.req0_mode);
        end
        ovf_s    = sum_ovf(sum_s);
        accept_s = rst_n && any_valid_s && slot_free_s;
    end

    assign bus.req0_ready = accept_s && !win1_s;
    assign bus.req1_ready = accept_s && win1_s;

    // Next-state for the EMPTY/FULL result slot, its payload and the debug counter.
    always_comb begin
        state_d     = state_q;
        res_data_d  = res_data_q;
        res_ovf_d   = res_ovf_q;
        res_id_d    = res_id_q;
        last_d      = last_q;
        ovf_count_d = ovf_count_q;
        case (state_q)
            EMPTY: begin
                if (accept_s) begin
                    state_d = FULL;
                end else begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (accept_s) begin
                    state_d = FULL;
                end else if (bus.res_ready) begin
                    state_d = EMPTY;
                end else begin
                    state_d = FULL;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (accept_s) begin
            res_data_d = sum_s[RES_W-1:0];
            res_ovf_d  = ovf_s;
            res_id_d   = win1_s;
            last_d     = win1_s;
            if (ovf_s && (ovf_count_q != CNT_MAX)) begin
                ovf_count_d = ovf_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                ovf_count_d = ovf_count_q;
            end
        end else begin
            res_data_d = res_data_q;
        end
    end

    // State registers; last resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            res_data_q  <= {RES_W{1'b0}};
            res_ovf_q   <= 1'b0;
            res_id_q    <= 1'b0;
            last_q      <= 1'b1;
            ovf_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            res_data_q  <= res_data_d;
            res_ovf_q   <= res_ovf_d;
            res_id_q    <= res_id_d;
            last_q      <= last_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign bus.res_valid = (state_q == FULL);
    assign bus.res_data  = res_data_q;
    assign bus.res_ovf   = res_ovf_q;
    assign bus.res_id    = res_id_q;
    assign bus.ovf_count = ovf_count_q;
endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Directed bench for shared_adder_arbiter (RES_W=4, CNT_W=2) with hand-computed results.
module tb_shared_adder_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    shared_adder_arbiter_if #(.A_W(4), .B_W(3), .RES_W(4), .CNT_W(2)) bus ();

    shared_adder_arbiter #(.A_W(4), .B_W(3), .RES_W(4), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_a = 4'd0; bus.req0_b = 3'd0; bus.req0_mode = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = 4'd0; bus.req1_b = 3'd0; bus.req1_mode = 1'b0;
        bus.res_ready  = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.res_valid); end
        checks++; if (bus.res_data !== 4'h0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.res_data); end
        checks++; if ({bus.res_ovf, bus.res_id} !== 2'b00) begin errors++; $display("FAIL reset_ovf_id got %b exp 00", {bus.res_ovf, bus.res_id}); end
        checks++; if (bus.ovf_count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.ovf_count); end
        checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", bus.req0_ready); end
        bus.req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sign();
        bus.req0_valid = 1'b1; bus.req0_a = 4'd13; bus.req0_b = 3'd2; bus.req0_mode = 1'b0;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL sign_ready got %b exp 1", bus.req0_ready); end
        @(posedge clk); #1;
        bus.req0_mode = 1'b1;
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL sign_u_valid got %b exp 1", bus.res_valid); end
        checks++; if (bus.res_data !== 4'b1111) begin errors++; $display("FAIL sign_u_data got %h exp f", bus.res_data); end
        checks++; if (bus.res_ovf !== 1'b1) begin errors++; $display("FAIL sign_u_ovf got %b exp 1", bus.res_ovf); end
        checks++; if (bus.res_id !== 1'b0) begin errors++; $display("FAIL sign_u_id got %b exp 0", bus.res_id); end
        checks++; if (bus.ovf_count !== 2'd1) begin errors++; $display("FAIL sign_u_count got %0d exp 1", bus.ovf_count); end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        checks++; if (bus.res_data !== 4'b1111) begin errors++; $display("FAIL sign_s_data got %h exp f", bus.res_data); end
        checks++; if (bus.res_ovf !== 1'b0) begin errors++; $display("FAIL sign_s_ovf got %b exp 0", bus.res_ovf); end
        checks++; if (bus.ovf_count !== 2'd1) begin errors++; $display("FAIL sign_s_count got %0d exp 1", bus.ovf_count); end
        @(posedge clk); #1;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", bus.res_valid); end
    endtask

    task automatic test_neg_b();
        bus.req1_valid = 1'b1; bus.req1_a = 4'b0000; bus.req1_b = 3'b111; bus.req1_mode = 1'b0;
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        checks++; if (bus.res_data !== 4'b1111) begin errors++; $display("FAIL negb_data got %h exp f", bus.res_data); end
        checks++; if (bus.res_ovf !== 1'b0) begin errors++; $display("FAIL negb_ovf got %b exp 0", bus.res_ovf); end
        checks++; if (bus.res_id !== 1'b1) begin errors++; $display("FAIL negb_id got %b exp 1", bus.res_id); end
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        logic       exp_id;
        logic [3:0] exp_data;
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 4'd1; bus.req0_b = 3'd1; bus.req0_mode = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 4'd2; bus.req1_b = 3'd1; bus.req1_mode = 1'b0;
        bus.res_ready  = 1'b1;
        exp_id = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if ({bus.req1_ready, bus.req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin errors++; $display("FAIL cont_ready%0d got %b exp %b", i, {bus.req1_ready, bus.req0_ready}, (exp_id ? 2'b10 : 2'b01)); end
            @(posedge clk); #1;
            exp_data = exp_id ? 4'd3 : 4'd2;
            checks++; if (bus.res_id !== exp_id) begin errors++; $display("FAIL cont_id%0d got %b exp %b", i, bus.res_id, exp_id); end
            checks++; if (bus.res_data !== exp_data) begin errors++; $display("FAIL cont_data%0d got %h exp %h", i, bus.res_data, exp_data); end
            exp_id = ~exp_id;
        end
    endtask

    task automatic test_backpressure();
        bus.res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready%0d got %b exp 00", i, {bus.req1_ready, bus.req0_ready}); end
            @(posedge clk); #1;
            checks++; if ({bus.res_valid, bus.res_id, bus.res_data} !== {1'b1, 1'b1, 4'd3}) begin errors++; $display("FAIL bp_hold%0d got %b exp 1_1_0011", i, {bus.res_valid, bus.res_id, bus.res_data}); end
        end
        bus.res_ready = 1'b1;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", bus.req0_ready); end
        @(posedge clk); #1;
        checks++; if ({bus.res_id, bus.res_data} !== {1'b0, 4'd2}) begin errors++; $display("FAIL bp_release_res got %b exp 0_0010", {bus.res_id, bus.res_data}); end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 4'd7; bus.req0_b = 3'd1; bus.req0_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.ovf_count !== exp_cnt[i]) begin errors++; $display("FAIL sat_count%0d got %0d exp %0d", i, bus.ovf_count, exp_cnt[i]); end
            checks++; if ({bus.res_ovf, bus.res_data} !== 5'b1_1000) begin errors++; $display("FAIL sat_res%0d got %b exp 1_1000", i, {bus.res_ovf, bus.res_data}); end
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        bus.res_ready  = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 4'd7; bus.req0_b = 3'd1; bus.req0_mode = 1'b1;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL ares_pre_valid got %b exp 1", bus.res_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL ares_valid got %b exp 0", bus.res_valid); end
        checks++; if (bus.ovf_count !== 2'd0) begin errors++; $display("FAIL ares_count got %0d exp 0", bus.ovf_count); end
        checks++; if (bus.res_data !== 4'h0) begin errors++; $display("FAIL ares_data got %h exp 0", bus.res_data); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.res_ready  = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 4'd1; bus.req0_b = 3'd1; bus.req0_mode = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 4'd2; bus.req1_b = 3'd1; bus.req1_mode = 1'b0;
        #1;
        checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin errors++; $display("FAIL ares_tie_ready got %b exp 01", {bus.req1_ready, bus.req0_ready}); end
        @(posedge clk); #1;
        checks++; if ({bus.res_valid, bus.res_id, bus.res_data} !== {1'b1, 1'b0, 4'd2}) begin errors++; $display("FAIL ares_tie_res got %b exp 1_0_0010", {bus.res_valid, bus.res_id, bus.res_data}); end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sign();
        test_neg_b();
        test_contention();
        test_backpressure();
        test_saturation();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shared_adder_arbiter.md
Name: shared_adder_arbiter

Overview:
- Shares one mixed-signedness adder between two requesters using valid/ready handshakes and round-robin arbitration.
- Each request supplies an operand `a` that the requester marks as unsigned or signed, plus a signed operand `b`.
- The block registers a wrapped `RES_W`-bit signed sum, an overflow flag and the requester ID, held for a downstream consumer.
- It also keeps a saturating count of overflowing results for debug readout.

Parameters:
- A_W, 4, width of operand a; must satisfy A_W <= RES_W.
- B_W, 3, width of signed operand b; must satisfy B_W <= RES_W.
- RES_W, 4, width of the signed result.
- CNT_W, 8, width of the overflow event counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  A_W  operand a, requester 0.
- req0_b  input  B_W  operand b (signed), requester 0.
- req0_mode  input  1  1: a is signed; 0: a is unsigned.
- req1_valid, req1_ready, req1_a, req1_b, req1_mode: same as requester 0, for requester 1.
- res_valid  output  1  result register holds a result.
- res_ready  input  1  consumer takes the result.
- res_data  output  RES_W  wrapped signed sum.
- res_ovf  output  1  true sum outside the signed RES_W range.
- res_id  output  1  requester that produced the result.
- ovf_count  output  CNT_W  saturating count of results with res_ovf=1.

Behaviour:
- Reset (async assert, sync release): res_valid=0, res_data=0, res_ovf=0, res_id=0, ovf_count=0, round-robin pointer last=1 (so requester 0 wins first). While rst_n=0 no request is accepted.
- Slot free: `slot_free = !res_valid || res_ready`.
- Grant, combinational:
  - Only one requester valid: that requester wins.
  - Both valid: the requester != last wins.
  - req*_ready = (winner == that requester) && slot_free. At most one ready is high per cycle.
- Accept: on the edge where reqX_valid && reqX_ready:
  - the result register loads the sum, ovf and res_id=X;
  - last <= X;
  - res_valid <= 1.
- Drain: on an edge with res_valid && res_ready and no accept, res_valid <= 0.
- Simultaneous drain and accept: the new result replaces the old one; res_valid stays 1. This gives a throughput of 1 op/cycle.
- Latency: a result is visible on res_* the cycle after its accept edge.
- Stall: while res_valid=1 and res_ready=0, res_* are held stable and both readies are 0.
- Requester obligation: a requester keeps valid and its operands stable until ready. The block does not check this.
- State view: EMPTY (res_valid=0) and FULL (res_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on stall, or on drain with accept.
- Arithmetic, at width RES_W+1:
  - a_ext = mode ? sign-extend(a) : zero-extend(a).
  - b_ext = sign-extend(b).
  - sum = a_ext + b_ext.
  - res_data = sum[RES_W-1:0], i.e. two's-complement wrap.
  - res_ovf = (sum[RES_W] != sum[RES_W-1]).
- ovf_count: increments by 1 on each accept whose computed ovf=1. It saturates at 2^CNT_W-1 and never wraps.
- Reset mid-operation: an asserted rst_n immediately clears all state. An accepted but undelivered result is discarded.

Test Plan:
- Sign interpretation, req0 only, RES_W=4, a=13, b=2:
  - mode=0 -> one cycle later res_data=4'b1111 (-1), res_ovf=1, res_id=0, ovf_count=1.
  - Repeat with mode=1 -> res_data=-1, res_ovf=0, ovf_count unchanged.
- Negative b, req1 only: a=4'b0000, b=3'b111 (-1), mode=0 -> res_data=4'b1111, res_ovf=0, res_id=1.
- Contention:
  - Both valid continuously and res_ready=1 -> grants alternate 0,1,0,1 after reset; one result per cycle; the res_id sequence matches.
  - Held-valid requester 1 is never starved beyond one cycle.
- Backpressure:
  - res_ready=0 for 5 cycles with both requesters valid -> res_* frozen, both readies 0.
  - Release res_ready -> the next winner's result appears the following cycle.
- Saturation: CNT_W=2; 5 overflowing ops (a=7, b=1, mode=1) -> ovf_count reads 1,2,3,3,3.
- Async reset: assert rst_n=0 mid-cycle while res_valid=1 -> res_valid=0 and ovf_count=0 without waiting for a clock edge; after release, requester 0 wins a tie.
